// File: rtl/alu_reservation_station_pkg.sv
// Shared widths and opcode encoding for the ALU reservation station and the ALU behind it.
package alu_reservation_station_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    OP_RESET = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_ADDI  = 4'd6,
    OP_BEQ   = 4'd7,
    OP_JAL   = 4'd8
  } op_e;
endpackage

// File: rtl/alu_reservation_station_prio.sv
// Lowest-index priority encoder: one-hot grant, binary index and a found flag.
module rs_priority_select #(
  parameter int N  = 16,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        found     = 1'b1;
        idx       = i[IW-1:0];
        onehot[i] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_reservation_station.sv
// Reservation station feeding the combinational ALU; snoops ALU and LSB CDB ports.
// Optional RS_BYPASS_EN: operand-complete issues skip the buffer when nothing stored is ready.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int RS_SIZE       = 16,
  parameter int ROB_TAG_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     rollback,
  input  logic                     issue_valid,
  input  logic [OP_W-1:0]          issue_op_enum,
  input  logic [DATA_W-1:0]        issue_V1,
  input  logic [DATA_W-1:0]        issue_V2,
  input  logic [ROB_TAG_WIDTH-1:0] issue_Q1,
  input  logic [ROB_TAG_WIDTH-1:0] issue_Q2,
  input  logic                     issue_Q1_valid,
  input  logic                     issue_Q2_valid,
  input  logic [DATA_W-1:0]        issue_imm,
  input  logic [ADDR_W-1:0]        issue_inst_pos,
  input  logic [ROB_TAG_WIDTH-1:0] issue_rob_tag,
  input  logic                     cdb_alu_valid,
  input  logic [ROB_TAG_WIDTH-1:0] cdb_alu_tag,
  input  logic [DATA_W-1:0]        cdb_alu_result,
  input  logic                     cdb_lsb_valid,
  input  logic [ROB_TAG_WIDTH-1:0] cdb_lsb_tag,
  input  logic [DATA_W-1:0]        cdb_lsb_result,
  output logic                     full,
  output logic [OP_W-1:0]          alu_op_enum,
  output logic [DATA_W-1:0]        alu_V1,
  output logic [DATA_W-1:0]        alu_V2,
  output logic [DATA_W-1:0]        alu_imm,
  output logic [ADDR_W-1:0]        alu_inst_pos,
  output logic [ROB_TAG_WIDTH-1:0] alu_rob_tag
);
  localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0]       busy, q1v, q2v, ready, free_oh, ready_oh;
  logic [OP_W-1:0]          op   [RS_SIZE];
  logic [DATA_W-1:0]        v1   [RS_SIZE];
  logic [DATA_W-1:0]        v2   [RS_SIZE];
  logic [DATA_W-1:0]        imm  [RS_SIZE];
  logic [ADDR_W-1:0]        pc   [RS_SIZE];
  logic [ROB_TAG_WIDTH-1:0] q1   [RS_SIZE];
  logic [ROB_TAG_WIDTH-1:0] q2   [RS_SIZE];
  logic [ROB_TAG_WIDTH-1:0] tag  [RS_SIZE];
  logic [IW-1:0]            free_idx, rdy_idx;
  logic                     free_found, rdy_found;

  assign ready = busy & ~q1v & ~q2v;
  assign full  = &busy;

  rs_priority_select #(.N(RS_SIZE), .IW(IW)) u_free_sel (
    .req(~busy), .onehot(free_oh), .idx(free_idx), .found(free_found)
  );
  rs_priority_select #(.N(RS_SIZE), .IW(IW)) u_ready_sel (
    .req(ready), .onehot(ready_oh), .idx(rdy_idx), .found(rdy_found)
  );

  // Incoming operands see the same-cycle broadcast; ALU port wins on a double match.
  logic in_a1, in_l1, in_a2, in_l2, in_q1v, in_q2v, do_byp, do_issue;
  logic [DATA_W-1:0] in_v1, in_v2;

  always_comb begin
    in_a1  = issue_Q1_valid && cdb_alu_valid && cdb_alu_tag == issue_Q1;
    in_l1  = issue_Q1_valid && cdb_lsb_valid && cdb_lsb_tag == issue_Q1;
    in_a2  = issue_Q2_valid && cdb_alu_valid && cdb_alu_tag == issue_Q2;
    in_l2  = issue_Q2_valid && cdb_lsb_valid && cdb_lsb_tag == issue_Q2;
    in_q1v = issue_Q1_valid && !in_a1 && !in_l1;
    in_q2v = issue_Q2_valid && !in_a2 && !in_l2;
    in_v1  = in_a1 ? cdb_alu_result : in_l1 ? cdb_lsb_result : issue_V1;
    in_v2  = in_a2 ? cdb_alu_result : in_l2 ? cdb_lsb_result : issue_V2;
`ifdef RS_BYPASS_EN
    do_byp = issue_valid && !in_q1v && !in_q2v && !rdy_found;
`else
    do_byp = 1'b0;
`endif
    do_issue = issue_valid && !full && free_found && !do_byp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= '0;
      alu_op_enum  <= OP_RESET;
      alu_V1       <= '0;
      alu_V2       <= '0;
      alu_imm      <= '0;
      alu_inst_pos <= '0;
      alu_rob_tag  <= '0;
    end else if (rdy) begin
      if (rollback) begin
        busy        <= '0;
        alu_op_enum <= OP_RESET;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && q1v[i]) begin
            if (cdb_alu_valid && cdb_alu_tag == q1[i]) begin
              v1[i] <= cdb_alu_result; q1v[i] <= 1'b0;
            end else if (cdb_lsb_valid && cdb_lsb_tag == q1[i]) begin
              v1[i] <= cdb_lsb_result; q1v[i] <= 1'b0;
            end
          end
          if (busy[i] && q2v[i]) begin
            if (cdb_alu_valid && cdb_alu_tag == q2[i]) begin
              v2[i] <= cdb_alu_result; q2v[i] <= 1'b0;
            end else if (cdb_lsb_valid && cdb_lsb_tag == q2[i]) begin
              v2[i] <= cdb_lsb_result; q2v[i] <= 1'b0;
            end
          end
        end

        if (rdy_found) begin
          alu_op_enum  <= op[rdy_idx];
          alu_V1       <= v1[rdy_idx];
          alu_V2       <= v2[rdy_idx];
          alu_imm      <= imm[rdy_idx];
          alu_inst_pos <= pc[rdy_idx];
          alu_rob_tag  <= tag[rdy_idx];
        end else if (do_byp) begin
          alu_op_enum  <= issue_op_enum;
          alu_V1       <= in_v1;
          alu_V2       <= in_v2;
          alu_imm      <= issue_imm;
          alu_inst_pos <= issue_inst_pos;
          alu_rob_tag  <= issue_rob_tag;
        end else begin
          alu_op_enum  <= OP_RESET;
        end

        // Free slot is never the dispatched slot, so clear and set cannot collide.
        busy <= (busy & ~ready_oh) | (do_issue ? free_oh : '0);
        if (do_issue) begin
          op[free_idx]  <= issue_op_enum;
          v1[free_idx]  <= in_v1;
          v2[free_idx]  <= in_v2;
          q1[free_idx]  <= issue_Q1;
          q2[free_idx]  <= issue_Q2;
          q1v[free_idx] <= in_q1v;
          q2v[free_idx] <= in_q2v;
          imm[free_idx] <= issue_imm;
          pc[free_idx]  <= issue_inst_pos;
          tag[free_idx] <= issue_rob_tag;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: per-cycle vector table plus hand sequences.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

`ifdef RS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, rollback;
  logic        issue_valid, issue_Q1_valid, issue_Q2_valid;
  logic [3:0]  issue_op_enum, issue_Q1, issue_Q2, issue_rob_tag;
  logic [31:0] issue_V1, issue_V2, issue_imm, issue_inst_pos;
  logic        cdb_alu_valid, cdb_lsb_valid;
  logic [3:0]  cdb_alu_tag, cdb_lsb_tag;
  logic [31:0] cdb_alu_result, cdb_lsb_result;
  logic        full;
  logic [3:0]  alu_op_enum, alu_rob_tag;
  logic [31:0] alu_V1, alu_V2, alu_imm, alu_inst_pos;

  alu_reservation_station #(.RS_SIZE(16), .ROB_TAG_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .issue_valid(issue_valid), .issue_op_enum(issue_op_enum),
    .issue_V1(issue_V1), .issue_V2(issue_V2), .issue_Q1(issue_Q1), .issue_Q2(issue_Q2),
    .issue_Q1_valid(issue_Q1_valid), .issue_Q2_valid(issue_Q2_valid),
    .issue_imm(issue_imm), .issue_inst_pos(issue_inst_pos), .issue_rob_tag(issue_rob_tag),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_result(cdb_alu_result),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_result(cdb_lsb_result),
    .full(full), .alu_op_enum(alu_op_enum), .alu_V1(alu_V1), .alu_V2(alu_V2),
    .alu_imm(alu_imm), .alu_inst_pos(alu_inst_pos), .alu_rob_tag(alu_rob_tag)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        iv;
    logic [3:0]  op;
    logic [31:0] v1, v2;
    logic        q1v; logic [3:0] q1;
    logic        q2v; logic [3:0] q2;
    logic [3:0]  tag;
    logic        av; logic [3:0] at; logic [31:0] ar;
    logic        lv; logic [3:0] lt; logic [31:0] lr;
    logic [3:0]  e_op;
    logic [31:0] e_v1, e_v2;
    logic [3:0]  e_tag;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic iv, logic [3:0] op, logic [31:0] v1, logic [31:0] v2,
                              logic q1v, logic [3:0] q1, logic q2v, logic [3:0] q2, logic [3:0] tag,
                              logic av, logic [3:0] at, logic [31:0] ar,
                              logic lv, logic [3:0] lt, logic [31:0] lr,
                              logic [3:0] eop, logic [31:0] ev1, logic [31:0] ev2, logic [3:0] etag);
    vec_t v;
    v.name = nm; v.iv = iv; v.op = op; v.v1 = v1; v.v2 = v2;
    v.q1v = q1v; v.q1 = q1; v.q2v = q2v; v.q2 = q2; v.tag = tag;
    v.av = av; v.at = at; v.ar = ar; v.lv = lv; v.lt = lt; v.lr = lr;
    v.e_op = eop; v.e_v1 = ev1; v.e_v2 = ev2; v.e_tag = etag;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_op_enum = OP_RESET; issue_V1 = 0; issue_V2 = 0;
    issue_Q1 = 0; issue_Q2 = 0; issue_Q1_valid = 0; issue_Q2_valid = 0;
    issue_imm = 0; issue_inst_pos = 0; issue_rob_tag = 0;
    cdb_alu_valid = 0; cdb_alu_tag = 0; cdb_alu_result = 0;
    cdb_lsb_valid = 0; cdb_lsb_tag = 0; cdb_lsb_result = 0;
    rollback = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [3:0] op, logic [31:0] v1, logic [31:0] v2,
                       logic q1v, logic [3:0] q1, logic [3:0] tag);
    idle();
    issue_valid = 1; issue_op_enum = op; issue_V1 = v1; issue_V2 = v2;
    issue_Q1_valid = q1v; issue_Q1 = q1; issue_rob_tag = tag;
    issue_imm = {28'd0, tag}; issue_inst_pos = 32'h1000 + {26'd0, tag, 2'b00};
  endtask

  initial begin
    idle();
    rst = 1; rdy = 0;
    step(); step();
    chk("reset_op", alu_op_enum, OP_RESET);
    chk("reset_v1", alu_V1, 0);
    chk("reset_tag", alu_rob_tag, 0);
    chk("reset_pc", alu_inst_pos, 0);
    chk("reset_full", full, 0);
    rst = 0; rdy = 1;

    vecs.push_back(mk("add_issue", 1, OP_ADD, 5, 7, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0,
                      BYP ? OP_ADD : OP_RESET, 5, 7, 2));
    vecs.push_back(mk("add_disp", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      BYP ? OP_RESET : OP_ADD, 5, 7, 2));
    vecs.push_back(mk("sub_issue", 1, OP_SUB, 0, 1, 1, 3, 0, 0, 4, 0, 0, 0, 0, 0, 0, OP_RESET, 0, 0, 0));
    vecs.push_back(mk("sub_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OP_RESET, 0, 0, 0));
    vecs.push_back(mk("sub_cdb", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h10, 0, 0, 0, OP_RESET, 0, 0, 0));
    vecs.push_back(mk("sub_disp", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OP_SUB, 32'h10, 1, 4));
    vecs.push_back(mk("lsb_same_cyc", 1, OP_ADD, 2, 0, 0, 0, 1, 9, 5, 0, 0, 0, 1, 9, 32'hABCD,
                      BYP ? OP_ADD : OP_RESET, 2, 32'hABCD, 5));
    vecs.push_back(mk("lsb_disp", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      BYP ? OP_RESET : OP_ADD, 2, 32'hABCD, 5));
    vecs.push_back(mk("and_issue", 1, OP_AND, 0, 0, 1, 6, 1, 7, 8, 0, 0, 0, 0, 0, 0, OP_RESET, 0, 0, 0));
    vecs.push_back(mk("and_both_cdb", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 32'h11, 1, 7, 32'h22, OP_RESET, 0, 0, 0));
    vecs.push_back(mk("and_disp", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OP_AND, 32'h11, 32'h22, 8));
    vecs.push_back(mk("drained", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OP_RESET, 0, 0, 0));

    foreach (vecs[k]) begin
      idle();
      issue_valid = vecs[k].iv; issue_op_enum = vecs[k].op;
      issue_V1 = vecs[k].v1; issue_V2 = vecs[k].v2;
      issue_Q1_valid = vecs[k].q1v; issue_Q1 = vecs[k].q1;
      issue_Q2_valid = vecs[k].q2v; issue_Q2 = vecs[k].q2;
      issue_rob_tag = vecs[k].tag;
      cdb_alu_valid = vecs[k].av; cdb_alu_tag = vecs[k].at; cdb_alu_result = vecs[k].ar;
      cdb_lsb_valid = vecs[k].lv; cdb_lsb_tag = vecs[k].lt; cdb_lsb_result = vecs[k].lr;
      step();
      chk({vecs[k].name, "_op"}, alu_op_enum, vecs[k].e_op);
      chk({vecs[k].name, "_full"}, full, 0);
      if (vecs[k].e_op != OP_RESET) begin
        chk({vecs[k].name, "_v1"}, alu_V1, vecs[k].e_v1);
        chk({vecs[k].name, "_v2"}, alu_V2, vecs[k].e_v2);
        chk({vecs[k].name, "_tag"}, alu_rob_tag, vecs[k].e_tag);
      end
    end

    // Fill all 16 entries, each waiting on its own tag.
    for (int i = 0; i < 16; i++) begin
      issue(OP_ADD, 0, i, 1, i[3:0], i[3:0]);
      step();
      if (i == 14) chk("full_at_15", full, 0);
    end
    chk("full_at_16", full, 1);
    issue(OP_SUB, 0, 32'h77, 1, 4'd5, 4'd7);
    step();
    chk("drop17_full", full, 1);
    chk("drop17_op", alu_op_enum, OP_RESET);
    idle(); cdb_alu_valid = 1; cdb_alu_tag = 0; cdb_alu_result = 32'h99;
    step();
    chk("free0_cdb_op", alu_op_enum, OP_RESET);
    chk("free0_cdb_full", full, 1);
    issue(OP_OR, 1, 2, 0, 0, 4'd12);
    step();
    chk("free0_disp_op", alu_op_enum, OP_ADD);
    chk("free0_disp_v1", alu_V1, 32'h99);
    chk("free0_disp_tag", alu_rob_tag, 0);
    chk("free0_full_clear", full, 0);
    idle();
    step();
    chk("dropped_or_absent", alu_op_enum, OP_RESET);
    cdb_lsb_valid = 1; cdb_lsb_tag = 5; cdb_lsb_result = 32'h55;
    step();
    idle();
    step();
    chk("e5_op", alu_op_enum, OP_ADD);
    chk("e5_v1", alu_V1, 32'h55);
    chk("e5_v2", alu_V2, 5);
    chk("e5_pc", alu_inst_pos, 32'h1014);
    step();
    chk("e17_not_stored", alu_op_enum, OP_RESET);
    rollback = 1;
    step();
    chk("flush_full", full, 0);
    idle();

    // Rollback with five pending entries and a same-cycle issue.
    for (int i = 1; i <= 5; i++) begin
      issue(OP_XOR, 0, 0, 1, i[3:0], i[3:0]);
      step();
    end
    issue(OP_XOR, 3, 4, 0, 0, 4'd3);
    rollback = 1;
    step();
    chk("rb_full", full, 0);
    chk("rb_op", alu_op_enum, OP_RESET);
    idle();
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) begin
        cdb_alu_valid = 1; cdb_alu_tag = i[3:0]; cdb_alu_result = 32'hDEAD;
      end else idle();
      step();
      chk("rb_no_disp", alu_op_enum, OP_RESET);
    end
    step();
    chk("rb_no_disp_end", alu_op_enum, OP_RESET);

    // rdy low drops issues and freezes the output registers.
    rdy = 0;
    issue(OP_SUB, 8, 9, 0, 0, 4'd10);
    step();
    rdy = 1; idle();
    step();
    chk("rdy_low_issue_drop", alu_op_enum, OP_RESET);
    issue(OP_ADD, 32'h30, 32'h40, 0, 0, 4'd9);
    step();
    idle();
    if (!BYP) step();
    chk("rdy_hold_pre", alu_op_enum, OP_ADD);
    rdy = 0;
    step();
    chk("rdy_hold_op", alu_op_enum, OP_ADD);
    chk("rdy_hold_tag", alu_rob_tag, 9);
    rdy = 1;
    step();
    chk("rdy_resume", alu_op_enum, OP_RESET);

`ifdef RS_BYPASS_EN
    issue(OP_ADDI, 32'h21, 0, 0, 0, 4'd6);
    issue_imm = 32'h100;
    step();
    idle();
    chk("byp_op", alu_op_enum, OP_ADDI);
    chk("byp_v1", alu_V1, 32'h21);
    chk("byp_imm", alu_imm, 32'h100);
    chk("byp_full", full, 0);
    step();
    chk("byp_not_stored", alu_op_enum, OP_RESET);
    for (int i = 0; i < 16; i++) begin
      issue(OP_ADD, 0, 0, 1, i[3:0], i[3:0]);
      step();
    end
    issue(OP_BEQ, 1, 1, 0, 0, 4'd3);
    step();
    chk("byp_when_full_op", alu_op_enum, OP_BEQ);
    chk("byp_when_full_full", full, 1);
    idle(); rollback = 1;
    step();
    idle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Tomasulo reservation station directly upstream of the combinational ALU.
- Buffers decoded arithmetic/branch/jump instructions from the dispatcher and snoops two CDB broadcast ports (ALU, LSB) for missing operands.
- Each cycle, registers at most one operand-complete entry onto the ALU input bus, tagged with its ROB index.

Parameters:
- RS_SIZE, 16, number of entries (power of two, 2..32).
- ROB_TAG_WIDTH, 4, width of ROB index used as rename tag.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes all state and outputs
- rollback  in  1  mispredict flush
- issue_valid  in  1  dispatcher writes one entry this cycle
- issue_op_enum  in  `OP_ENUM_TYPE  decoded op
- issue_V1, issue_V2  in  `DATA_TYPE  operand values
- issue_Q1, issue_Q2  in  ROB_TAG_WIDTH  producer tags
- issue_Q1_valid, issue_Q2_valid  in  1  1 = operand still pending on tag
- issue_imm  in  `DATA_TYPE  immediate
- issue_inst_pos  in  `ADDR_TYPE  instruction PC
- issue_rob_tag  in  ROB_TAG_WIDTH  destination ROB index
- cdb_alu_valid, cdb_lsb_valid  in  1  broadcast strobes
- cdb_alu_tag, cdb_lsb_tag  in  ROB_TAG_WIDTH  broadcast tags
- cdb_alu_result, cdb_lsb_result  in  `DATA_TYPE  broadcast values
- full  out  1  all entries busy
- alu_op_enum  out  `OP_ENUM_TYPE  registered; `OP_ENUM_RESET = no op
- alu_V1, alu_V2, alu_imm  out  `DATA_TYPE  registered operands
- alu_inst_pos  out  `ADDR_TYPE  registered PC
- alu_rob_tag  out  ROB_TAG_WIDTH  registered destination tag

Behaviour:
- Entry fields: busy, op, V1/Q1/Q1_valid, V2/Q2/Q2_valid, imm, pc, rob_tag. Entry is ready when busy && !Q1_valid && !Q2_valid.
- Reset (rst high at posedge): all busy cleared, alu_op_enum = `OP_ENUM_RESET, other alu_* outputs = 0. full = 0. rst has priority over rdy.
- rdy low: no state or output register updates; issue and CDB inputs that cycle are ignored. The CDB owner must hold broadcasts until rdy.
- Snoop: for every busy entry, if Qn_valid and (cdb_alu_valid && tag==Qn or cdb_lsb_valid && tag==Qn), capture result into Vn and clear Qn_valid. If both ports match, ALU port wins (identical tags never occur legally).
- Issue: on issue_valid && !full, write into lowest-index free entry. Same-cycle CDB match on an incoming pending tag is captured at write.
- Dispatch: lowest-index ready entry (state before this edge's snoop/issue) is copied to alu_* registers and its busy cleared. If none is ready, alu_op_enum <= `OP_ENUM_RESET and other alu_* hold.
- Latency: a CDB broadcast at edge N makes the entry eligible at edge N+1. An issued entry with ready operands dispatches no earlier than the edge after issue. This is the baseline; see RS_BYPASS_EN.
- full = combinational AND of busy vector. An issue while full is dropped. A dispatch freeing an entry at the same edge does not unblock that cycle.
- rollback (rdy high): all busy cleared, alu_op_enum <= `OP_ENUM_RESET, issue that cycle dropped.
- Immediate-form ops pass issue_Q2_valid=0; V2 is then don't-care.

Optional Feature:
- Macro RS_BYPASS_EN.
- Defined: if issue_valid, both operands are ready after same-cycle CDB capture, and no stored entry is ready, the incoming instruction goes straight to alu_* registers at that edge without occupying an entry. This is allowed even when full.
- Undefined: no bypass; behaviour exactly as above.

Decomposition:
- constants.v gains `RS_SIZE, `ROB_TAG_TYPE, `RS_IDX_TYPE, and reuses `OP_ENUM_TYPE/`DATA_TYPE/`ADDR_TYPE/`OP_ENUM_RESET.
- Sub-module rs_priority_select: parameterised lowest-index one-hot/index encoder plus found flag.
- Instantiated twice in the station: once for the free slot, once for the ready slot.

Test Plan:
- Reset then issue ADD V1=5, V2=7, both ready at edge 1 -> edge 2: alu_op_enum=ADD, V1=5, V2=7, alu_rob_tag=issued tag; edge 3: `OP_ENUM_RESET.
- Issue SUB with Q1=3 pending; cdb_alu tag 3 result 0x10 two cycles later -> dispatch one edge after broadcast with alu_V1=0x10.
- Issue with Q2=9 pending while cdb_lsb broadcasts tag 9, value 0xABCD, same cycle -> entry ready; dispatch next edge with V2=0xABCD.
- Fill 16 pending entries -> full=1; 17th issue dropped. Broadcast a tag freeing entry 0 -> dispatch, then full=0 next cycle.
- Fill 5 entries, assert rollback -> full=0, alu_op_enum=`OP_ENUM_RESET; later broadcasts of old tags produce no dispatch.
- With RS_BYPASS_EN, empty station, issue ready ADDI -> alu outputs valid the next edge and busy vector stays zero.
